conv_output_writer: RTL and testbench

- Downstream stage of the Winograd 4x4 conv core.
- Consumes the per-kernel pooled/activated outputs (data_valid/data per kernel) and buffers them in a small FIFO.
- Writes them to a feature-map memory in kernel-major layout.
- Throttles the core through per-kernel hold lines and flags layer completion.

---
 rtl/conv_output_writer.sv | 151 +++++++++++++++
 tb/tb_conv_output_writer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_output_writer.sv
// Output writer for the Winograd conv core: captures per-kernel samples into a FIFO,
// writes them to feature-map memory in kernel-major layout and flags layer completion.
//
// state | meaning
// RUN   | accepting samples from the core
// DRAIN | every map fully captured; FIFO and output register emptying
// DONE  | every map written; layer_done_o high until reset
module conv_output_writer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int N_KERNELS  = 64,
  parameter int OUT_ROWS   = 13,
  parameter int OUT_COLS   = 13,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  input  logic [N_KERNELS-1:0]                 data_valid_i,
  input  logic [N_KERNELS-1:0][DATA_WIDTH-1:0] data_i,
  output logic [N_KERNELS-1:0]                 hold_data_o,
  input  logic                                 mem_ready_i,
  output logic                                 mem_we_o,
  output logic [ADDR_WIDTH-1:0]                mem_addr_o,
  output logic [DATA_WIDTH-1:0]                mem_data_o,
  output logic                                 layer_done_o,
  output logic                                 error_o
);

  localparam int MAP   = OUT_ROWS * OUT_COLS;
  localparam int CNT_W = $clog2(MAP) + 1;
  localparam int K_W   = (N_KERNELS > 1) ? $clog2(N_KERNELS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = PTR_W + 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [K_W-1:0]        fifo_k    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [FC_W-1:0]       fifo_count;
  logic [CNT_W-1:0]      push_cnt  [N_KERNELS];
  logic [CNT_W-1:0]      wr_cnt    [N_KERNELS];
  logic                  out_full;
  logic [K_W-1:0]        out_k;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  error_q;

  logic                  any_valid, multi_valid;
  logic [K_W-1:0]        sel_k;
  logic                  fifo_full, accept, pop, push, capture_err;
  logic [K_W-1:0]        head_k;
  logic [CNT_W-1:0]      wr_base;
  logic [ADDR_WIDTH-1:0] addr_calc;
  logic                  all_pushed, all_written, hold;

  always_comb begin
    sel_k = '0;
    for (int i = N_KERNELS - 1; i >= 0; i--) begin
      if (data_valid_i[i]) sel_k = K_W'(i);
    end
  end

  assign any_valid   = |data_valid_i;
  assign multi_valid = |(data_valid_i & (data_valid_i - N_KERNELS'(1)));
  assign fifo_full   = (fifo_count == FC_W'(FIFO_DEPTH));
  assign accept      = out_full && mem_ready_i;
  assign pop         = (fifo_count != '0) && (!out_full || accept);
  // A full FIFO still takes a sample when the head leaves on the same edge.
  assign push        = any_valid && !(fifo_full && !pop) &&
                       (push_cnt[sel_k] != CNT_W'(MAP)) && (state_q != S_DONE);
  assign capture_err = any_valid && (multi_valid || !push);

  // The write being accepted this edge may belong to the same kernel as the head.
  assign head_k    = fifo_k[rd_ptr];
  assign wr_base   = wr_cnt[head_k] + CNT_W'(accept && (out_k == head_k));
  assign addr_calc = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(head_k) * ADDR_WIDTH'(MAP)
                     + ADDR_WIDTH'(wr_base);

  always_comb begin
    all_pushed  = 1'b1;
    all_written = 1'b1;
    for (int i = 0; i < N_KERNELS; i++) begin
      if (push_cnt[i] != CNT_W'(MAP)) all_pushed = 1'b0;
      if (wr_cnt[i] != CNT_W'(MAP))   all_written = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (all_pushed) state_d = S_DRAIN;
      S_DRAIN: if ((fifo_count == '0) && !out_full && all_written) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_full   <= 1'b0;
      out_k      <= '0;
      out_addr   <= '0;
      out_data   <= '0;
      error_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_k[i]    <= '0;
        fifo_data[i] <= '0;
      end
      for (int i = 0; i < N_KERNELS; i++) begin
        push_cnt[i] <= '0;
        wr_cnt[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      error_q    <= error_q | capture_err;
      fifo_count <= fifo_count + FC_W'(push) - FC_W'(pop);
      if (push) begin
        fifo_k[wr_ptr]    <= sel_k;
        fifo_data[wr_ptr] <= data_i[sel_k];
        wr_ptr            <= wr_ptr + PTR_W'(1);
        push_cnt[sel_k]   <= push_cnt[sel_k] + CNT_W'(1);
      end
      if (accept) wr_cnt[out_k] <= wr_cnt[out_k] + CNT_W'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        out_full <= 1'b1;
        out_k    <= head_k;
        out_data <= fifo_data[rd_ptr];
        out_addr <= addr_calc;
      end else if (accept) begin
        out_full <= 1'b0;
      end
    end
  end

  assign hold         = (fifo_count >= FC_W'(FIFO_DEPTH - 2)) && (state_q != S_DONE);
  assign hold_data_o  = {N_KERNELS{hold}};
  assign mem_we_o     = out_full;
  assign mem_addr_o   = out_addr;
  assign mem_data_o   = out_data;
  assign layer_done_o = (state_q == S_DONE);
  assign error_o      = error_q;

endmodule

// File: tb/tb_conv_output_writer.sv
// Scoreboard bench for conv_output_writer: a full-size instance and a 2-kernel 2x2 instance.
module tb_conv_output_writer;

  localparam int NA = 64;
  localparam int MA = 169;
  localparam int NS = 2;
  localparam int MS = 4;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NA-1:0]       valid_a;
  logic [NA-1:0][31:0] data_a;
  logic [NA-1:0]       hold_a;
  logic                ready_a, we_a, done_a, err_a;
  logic [15:0]         addr_a;
  logic [31:0]         wdata_a;

  logic [NS-1:0]       valid_s;
  logic [NS-1:0][31:0] data_s;
  logic [NS-1:0]       hold_s;
  logic                ready_s, we_s, done_s, err_s;
  logic [15:0]         addr_s;
  logic [31:0]         wdata_s;

  conv_output_writer dut_a (
    .clock_i(clk), .reset_i(rst), .data_valid_i(valid_a), .data_i(data_a),
    .hold_data_o(hold_a), .mem_ready_i(ready_a), .mem_we_o(we_a), .mem_addr_o(addr_a),
    .mem_data_o(wdata_a), .layer_done_o(done_a), .error_o(err_a)
  );

  conv_output_writer #(.N_KERNELS(NS), .OUT_ROWS(2), .OUT_COLS(2)) dut_s (
    .clock_i(clk), .reset_i(rst), .data_valid_i(valid_s), .data_i(data_s),
    .hold_data_o(hold_s), .mem_ready_i(ready_s), .mem_we_o(we_s), .mem_addr_o(addr_s),
    .mem_data_o(wdata_s), .layer_done_o(done_s), .error_o(err_s)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t qa[$];
  exp_t qs[$];
  int   cnt_a[NA];
  int   cnt_s[NS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && we_a && ready_a) begin
      check("a_write_expected", 64'(qa.size() != 0), 64'd1);
      if (qa.size() != 0) begin
        exp_t e;
        e = qa.pop_front();
        check("a_addr", 64'(addr_a), 64'(e.addr));
        check("a_data", 64'(wdata_a), 64'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && we_s && ready_s) begin
      check("s_write_expected", 64'(qs.size() != 0), 64'd1);
      if (qs.size() != 0) begin
        exp_t e;
        e = qs.pop_front();
        check("s_addr", 64'(addr_s), 64'(e.addr));
        check("s_data", 64'(wdata_s), 64'(e.data));
      end
    end
  end

  task automatic clear_model();
    qa.delete();
    qs.delete();
    for (int i = 0; i < NA; i++) cnt_a[i] = 0;
    for (int i = 0; i < NS; i++) cnt_s[i] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ready_a = 1'b0;
    ready_s = 1'b0;
    valid_a = '0;
    valid_s = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pulse_a(input int k, input logic [31:0] v, input bit stored);
    exp_t e;
    data_a[k] = v;
    valid_a = '0;
    valid_a[k] = 1'b1;
    if (stored) begin
      e.addr = 16'(k * MA + cnt_a[k]);
      e.data = v;
      qa.push_back(e);
      cnt_a[k]++;
    end
    @(posedge clk);
    #1;
    valid_a = '0;
  endtask

  task automatic pulse_s(input int k, input logic [31:0] v, input bit stored);
    exp_t e;
    data_s[k] = v;
    valid_s = '0;
    valid_s[k] = 1'b1;
    if (stored) begin
      e.addr = 16'(k * MS + cnt_s[k]);
      e.data = v;
      qs.push_back(e);
      cnt_s[k]++;
    end
    @(posedge clk);
    #1;
    valid_s = '0;
  endtask

  task automatic wait_drain_a(input int budget);
    int n = 0;
    while (qa.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("a_drained", 64'(qa.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    data_a = '0;
    data_s = '0;
    do_reset();

    // reset values
    check("rst_we", 64'(we_a), 64'd0);
    check("rst_addr", 64'(addr_a), 64'd0);
    check("rst_data", 64'(wdata_a), 64'd0);
    check("rst_hold", 64'(hold_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_err", 64'(err_a), 64'd0);
    check("rst_s_we_done_err", 64'({we_s, done_s, err_s, hold_s}), 64'd0);

    // single pulse latency
    ready_a = 1'b1;
    pulse_a(3, 32'h0001_2345, 1'b1);
    check("lat_we_e0", 64'(we_a), 64'd0);
    @(posedge clk); #1;
    check("lat_we_e1", 64'(we_a), 64'd1);
    check("lat_addr", 64'(addr_a), 64'd507);
    check("lat_data", 64'(wdata_a), 64'h0001_2345);
    @(posedge clk); #1;
    check("lat_we_once", 64'(we_a), 64'd0);
    wait_drain_a(10);

    // memory stall
    do_reset();
    for (int i = 1; i <= 3; i++) pulse_a(0, 32'(i), 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      ok &= (we_a === 1'b1) && (addr_a === 16'd0) && (wdata_a === 32'd1);
    end
    check("stall_stable", 64'(ok), 64'd1);
    ready_a = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ok &= (we_a === 1'b1);
      @(posedge clk); #1;
    end
    check("stall_back_to_back", 64'(ok), 64'd1);
    check("stall_we_off", 64'(we_a), 64'd0);
    wait_drain_a(10);

    // backpressure: output register plus FIFO_DEPTH entries, then overflow
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      pulse_a(5, 32'h500 + 32'(i), i <= 9);
      check($sformatf("bp_hold_%0d", i), 64'(hold_a), (i >= 7) ? 64'(~(NA)'(0)) : 64'd0);
      check($sformatf("bp_err_%0d", i), 64'(err_a), 64'(i == 10));
    end
    ready_a = 1'b1;
    wait_drain_a(40);
    check("bp_hold_released", 64'(hold_a), 64'd0);

    // double valid
    do_reset();
    ready_a = 1'b1;
    begin
      exp_t e;
      e.addr = 16'(2 * MA);
      e.data = 32'hAAAA_0002;
      qa.push_back(e);
    end
    data_a[2] = 32'hAAAA_0002;
    data_a[9] = 32'h9999_0009;
    valid_a[2] = 1'b1;
    valid_a[9] = 1'b1;
    @(posedge clk); #1;
    valid_a = '0;
    check("dv_err", 64'(err_a), 64'd1);
    wait_drain_a(10);
    repeat (4) @(posedge clk);
    #1;

    // full small layer
    do_reset();
    ready_s = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pulse_s(i % 2, 32'h100 + 32'(i), 1'b1);
      if (i == 6) check("full_not_done_early", 64'(done_s), 64'd0);
    end
    n = 0;
    while (!done_s && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("full_done", 64'(done_s), 64'd1);
    check("full_all_written", 64'(qs.size()), 64'd0);
    check("full_err_clean", 64'(err_s), 64'd0);
    check("full_done_quiet", 64'({we_s, hold_s}), 64'd0);
    pulse_s(0, 32'hDEAD_BEEF, 1'b0);
    check("full_extra_err", 64'(err_s), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("full_extra_no_we", 64'(we_s), 64'd0);
    check("full_done_sticky", 64'(done_s), 64'd1);

    // reset mid-operation
    do_reset();
    for (int i = 1; i <= 5; i++) pulse_a(1, 32'h600 + 32'(i), 1'b1);
    check("mid_we_busy", 64'(we_a), 64'd1);
    check("mid_addr_busy", 64'(addr_a), 64'(MA));
    rst = 1'b1;
    clear_model();
    @(posedge clk); #1;
    check("mid_rst_we", 64'(we_a), 64'd0);
    check("mid_rst_addr", 64'(addr_a), 64'd0);
    check("mid_rst_data", 64'(wdata_a), 64'd0);
    check("mid_rst_flags", 64'({hold_a, done_a, err_a}), 64'd0);
    rst = 1'b0;
    ready_a = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ok &= (we_a === 1'b0);
    end
    check("mid_fifo_empty", 64'(ok), 64'd1);
    pulse_a(0, 32'h0000_0777, 1'b1);
    wait_drain_a(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
